// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS lab register-file write path.
package mips_pkg;

  parameter int unsigned REGS_NUM   = 32;
  parameter int unsigned REGS_WIDTH = 32;
  parameter int unsigned REG_ADDR_W = $clog2(REGS_NUM);

  parameter logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One pending writeback: destination register and the value to write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REGS_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries.
// Pointers carry one extra MSB so full and empty are told apart by its toggle.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t     mem_q [DEPTH];

  // Flag decode from registered pointers only.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer advance; a push while full is legal only alongside a pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/regfile_wb_writer.sv
// Regfile write-port initiator: merges load and ALU writebacks, buffers ALU
// results that lose arbitration, and tracks per-register pending writes.
module regfile_wb_writer
  import mips_pkg::*;
#(
  parameter int unsigned ALU_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_waddr,
  input  logic [REGS_WIDTH-1:0] alu_wdata,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [REGS_WIDTH-1:0] mem_wdata,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_waddr,
  output logic [REGS_NUM-1:0]   busy,
  output logic                  waw_err,
  output logic                  fifo_empty,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REGS_WIDTH-1:0] wdata
);

  logic      fifo_full;
  logic      fifo_push;
  logic      fifo_pop;
  logic      alu_acc;
  wb_entry_t fifo_head;
  wb_entry_t alu_entry;
  wb_entry_t sel_entry;
  logic      sel_valid;

  logic                  we_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [REGS_WIDTH-1:0] wdata_q;
  logic [REGS_NUM-1:0]   busy_q, busy_d;
  logic                  waw_q, waw_d;

  assign alu_entry = '{addr: alu_waddr, data: alu_wdata};

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (alu_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Priority arbitration: load, then FIFO head, then ALU bypass.
  always_comb begin
    alu_ready = !fifo_full;
    alu_acc   = alu_valid && alu_ready;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    sel_valid = 1'b0;
    sel_entry = '0;
    if (mem_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{addr: mem_waddr, data: mem_wdata};
      fifo_push = alu_acc;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = alu_acc;
    end else if (alu_valid) begin
      // FIFO is empty here, so the ALU result is always accepted.
      sel_valid = 1'b1;
      sel_entry = alu_entry;
    end
  end

  // Scoreboard next state: commit clears, issue sets, set wins on a tie.
  always_comb begin
    busy_d = busy_q;
    waw_d  = waw_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (issue_valid) begin
      if (busy_q[issue_waddr]) waw_d = 1'b1;
      if (issue_waddr != REG_ZERO) busy_d[issue_waddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output register and scoreboard state; r0 writes consume a slot without we.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      waw_q   <= 1'b0;
    end else begin
      we_q   <= sel_valid && (sel_entry.addr != REG_ZERO);
      busy_q <= busy_d;
      waw_q  <= waw_d;
      if (sel_valid) begin
        waddr_q <= sel_entry.addr;
        wdata_q <= sel_entry.data;
      end
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign busy    = busy_q;
  assign waw_err = waw_q;

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Randomized bench for regfile_wb_writer against a queue-based reference model.
module tb_regfile_wb_writer;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_waddr;
  logic [REGS_WIDTH-1:0] alu_wdata;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_waddr;
  logic [REGS_WIDTH-1:0] mem_wdata;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_waddr;
  logic [REGS_NUM-1:0]   busy;
  logic                  waw_err;
  logic                  fifo_empty;
  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [REGS_WIDTH-1:0] wdata;

  regfile_wb_writer #(
    .ALU_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_waddr   (alu_waddr),
    .alu_wdata   (alu_wdata),
    .mem_valid   (mem_valid),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .busy        (busy),
    .waw_err     (waw_err),
    .fifo_empty  (fifo_empty),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ALU results wait in a plain queue; a pending write is a
  // set of register numbers in a bit array.
  wb_entry_t             m_q[$];
  logic                  m_we;
  logic [REG_ADDR_W-1:0] m_waddr;
  logic [REGS_WIDTH-1:0] m_wdata;
  logic [REGS_NUM-1:0]   m_busy;
  logic                  m_waw;
  bit                    m_addr_known;

  task automatic check_all();
    check_eq("we", we, m_we);
    if (m_we || m_addr_known) begin
      check_eq("waddr", waddr, m_waddr);
      check_eq("wdata", wdata, m_wdata);
    end
    check_eq("busy", busy, m_busy);
    check_eq("waw_err", waw_err, m_waw);
    check_eq("fifo_empty", fifo_empty, m_q.size() == 0);
    check_eq("alu_ready", alu_ready, m_q.size() < DEPTH);
  endtask

  // One cycle: check state left by the last edge, drive inputs, advance model.
  task automatic step(input bit r, input bit av, input logic [REG_ADDR_W-1:0] aa,
                      input logic [REGS_WIDTH-1:0] ad, input bit mv,
                      input logic [REG_ADDR_W-1:0] ma, input logic [REGS_WIDTH-1:0] md,
                      input bit iv, input logic [REG_ADDR_W-1:0] ia);
    bit                    acc;
    bit                    sel;
    wb_entry_t             e;
    logic [REGS_NUM-1:0]   nb;
    @(negedge clk);
    check_all();
    rst = r; alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    issue_valid = iv; issue_waddr = ia;
    if (r) begin
      m_q.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_waw = 0;
      m_addr_known = 1;
    end else begin
      acc = av && (m_q.size() < DEPTH);
      sel = 0;
      e   = '0;
      if (mv) begin
        sel = 1; e = '{addr: ma, data: md};
        if (acc) m_q.push_back('{addr: aa, data: ad});
      end else if (m_q.size() > 0) begin
        sel = 1; e = m_q.pop_front();
        if (acc) m_q.push_back('{addr: aa, data: ad});
      end else if (av) begin
        sel = 1; e = '{addr: aa, data: ad};
      end
      nb = m_busy;
      if (m_we) nb[m_waddr] = 1'b0;
      if (iv) begin
        if (m_busy[ia]) m_waw = 1;
        if (ia != 0) nb[ia] = 1'b1;
      end
      m_busy = nb;
      m_we = sel && (e.addr != 0);
      if (sel) begin
        m_waddr = e.addr;
        m_wdata = e.data;
      end
      m_addr_known = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    rst = 1; alu_valid = 0; alu_waddr = '0; alu_wdata = '0;
    mem_valid = 0; mem_waddr = '0; mem_wdata = '0; issue_valid = 0; issue_waddr = '0;
    m_q.delete(); m_we = 0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_waw = 0;
    m_addr_known = 0;
    repeat (2) @(posedge clk);
    // Reset under heavy traffic.
    step(1, 1, 5'd9, 32'h1234, 1, 5'd10, 32'h5678, 1, 5'd11);
    step(1, 1, 5'd12, 32'h9abc, 1, 5'd13, 32'hdef0, 1, 5'd14);
    idle();
    check_eq("post_reset_we", we, 0);
    check_eq("post_reset_busy", busy, 0);

    // Single ALU write to r5.
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd5);
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0);
    idle();
    idle();

    // Load/ALU collision.
    step(0, 1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 0, '0);
    idle();
    idle();
    idle();

    // Back-pressure: loads for 6 cycles while ALU offers r1..r6.
    begin
      int n = 1;
      for (int c = 0; c < 6; c++) begin
        step(0, n <= 6, REG_ADDR_W'(n), 32'hA0 + n, 1, 5'd20 + REG_ADDR_W'(c), 32'hB0 + c,
             0, '0);
        if (n <= 6 && m_q.size() <= DEPTH && alu_ready) n++;
      end
      for (int c = 0; c < 20; c++) begin
        step(0, n <= 6, REG_ADDR_W'(n), 32'hA0 + n, 0, '0, '0, 0, '0);
        if (n <= 6 && alu_ready) n++;
      end
      check_eq("bp_all_sent", n, 7);
    end

    // r0 handling.
    step(0, 1, 5'd0, 32'hFFFF, 0, '0, '0, 1, 5'd0);
    idle();
    idle();
    check_eq("r0_busy", busy[0], 0);

    // Scoreboard: issue r7 during its own commit, then again while busy.
    step(1, 0, '0, '0, 0, '0, '0, 0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7);
    step(0, 1, 5'd7, 32'h77, 0, '0, '0, 0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7);
    idle();
    check_eq("r7_busy_kept", busy[7], 1);
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7);
    idle();
    idle();
    check_eq("waw_sticky", waw_err, 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 6, REG_ADDR_W'($urandom_range(0, 9)), $urandom,
           $urandom_range(0, 9) < 3, REG_ADDR_W'($urandom_range(0, 9)), $urandom,
           $urandom_range(0, 9) < 4, REG_ADDR_W'($urandom_range(0, 9)));
    end
    for (int c = 0; c < 10; c++) idle();
    @(negedge clk);
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
